sd_cmd_responder: RTL and testbench
===================================

# sd_cmd_responder

Card-side SD command-line responder. It deserializes 48-bit host commands arriving on CMD, checks framing and CRC7, and decodes the command index and argument. For commands that need one, it serializes the response frame (R1 or R7) back on CMD. It serves as the card model opposite the microSD host initiator, both in simulation and in FPGA loopback builds on the IceSugar-Nano.

## Interface
Parameters:
- NCR, 2: SD_CLK periods between the command end bit and the response start bit (legal 2..64).
- CARD_STATUS, 32'h0000_0100: argument field returned in R1 responses.
- VHS_ACCEPT, 4'b0001: voltage-accepted nibble returned in R7.

Ports:
- CLK  input  1  system clock; every register is on posedge CLK.
- RST  input  1  synchronous, active-high reset.
- SD_CLK  input  1  SD bus clock from the host; it is sampled, not used as a clock.
- CMD_IN  input  1  CMD line value from the pad.
- CMD_OUT  output  1  CMD line drive value; reset 1.
- CMD_OE  output  1  CMD pad output enable; reset 0.
- CMD_VALID  output  1  one-CLK pulse when a well-framed command is received; reset 0.
- CMD_IDX  output  6  index of the last valid command; reset 0.
- CMD_ARG  output  32  argument of the last valid command; reset 0.
- CRC_ERR  output  1  one-CLK pulse on a CRC7 mismatch; reset 0.

## Operation
- SD_CLK and CMD_IN pass through 2-FF synchronizers. A rise or fall of the synchronized SD_CLK produces a one-CLK edge strobe.
- The block samples on SD_CLK rise and drives on SD_CLK fall.
- States:
  - IDLE: on a rise with CMD_IN=0 (start bit), clear the bit counter and CRC, then go to RX.
  - RX: shift one bit per rise, 47 more bits (48 total). Bit 46 must be 1; if it is 0, abort to IDLE with no flags. After bit 0, go to CHECK.
  - CHECK: one CLK.
    - End bit 0: go to IDLE, no flags.
    - CRC7 over bits 47..8 differs from bits 7..1: pulse CRC_ERR, go to IDLE.
    - Otherwise: latch CMD_IDX and CMD_ARG, pulse CMD_VALID, and select the response.
  - Response selection:
    - CMD0: no response; go to IDLE.
    - CMD8: R7 = 0, 0, 001000, 20'b0, VHS_ACCEPT, arg[7:0], CRC7, 1.
    - Any other index: R1 = 0, 0, idx, CARD_STATUS, CRC7, 1.
    - Go to NCR_WAIT.
  - NCR_WAIT: count NCR falls. On the NCR-th fall, set CMD_OE=1 and drive the response start bit, then go to TX.
  - TX: drive the next bit on each fall, MSB first, with the CRC7 computed serially over bits 47..8. On the fall after the end bit, set CMD_OE=0 and CMD_OUT=1, then go to IDLE.
- CMD_IN is ignored while in NCR_WAIT and TX.
- CRC7 uses polynomial x^7+x^3+1 with a zero seed. The same generator serves RX checking and TX generation.
- If SD_CLK stops, the state is held indefinitely. There is no timeout.

## Timing
- Synchronizer latency: an edge strobe fires 3 CLK after the SD_CLK pin edge.
- CMD_VALID and CRC_ERR pulse 1 CLK after the end-bit strobe. They are mutually exclusive.
- CMD_OE is high for exactly 48 SD_CLK periods per response.
- The response start bit is driven on the NCR-th SD_CLK fall after the command end bit is sampled.
- RST in any state: on the next CLK, state=IDLE, CMD_OE=0, CMD_OUT=1, counters=0, and no pulses fire. This includes reset mid-TX.
- Simultaneous rise strobe and RST: RST wins.

## Configuration
- SD_RESP_CRC_CHECK_EN defined: a CRC mismatch pulses CRC_ERR and suppresses the response.
- SD_RESP_CRC_CHECK_EN undefined:
  - The CRC comparison is removed and CRC_ERR is tied to 0.
  - Every well-framed command is accepted and, where applicable, answered.
  - The TX CRC generator is still built.

## Structure
- Shared package sd_pkg:
  - SD_FRAME_W=48.
  - CRC7 polynomial constant 7'h09.
  - Command indices SD_CMD0=6'd0, SD_CMD8=6'd8, SD_CMD55=6'd55.
  - Responder state enum.
  - Response-type enum (NONE, R1, R7).
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit-in inputs and a 7-bit output. It is shared with the host initiator.

## Test plan
- CMD0 frame 40 00 00 00 00 95 -> CMD_VALID, CMD_IDX=0, CMD_ARG=0, CRC_ERR=0, CMD_OE stays 0 for 100 SD_CLK.
- CMD8 frame 48 00 00 01 AA 87, NCR=2 -> CMD_IDX=8, CMD_ARG=32'h1AA. The response 08 00 00 01 AA 13 starts on the 2nd fall, and CMD_OE is high for 48 periods.
- CMD8 with last byte 01 -> with the macro: CRC_ERR pulse, no CMD_VALID, CMD_OE=0. Without the macro: response as in the CMD8 case.
- CMD55 frame 77 00 00 00 00 65 -> R1 with index 110111, argument 32'h0000_0100, and CRC7 matching the bench reference model.
- Start bit followed by transmission bit 0 -> return to IDLE, no flags. A following valid CMD0 is accepted.
- RST asserted at response bit 20 -> next CLK: CMD_OE=0, CMD_OUT=1. A subsequent CMD8 gets a complete response.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD command-line definitions: frame width, CRC7 polynomial,
// command indices and the responder state/response-type encodings.
package sd_pkg;

  localparam int unsigned SD_FRAME_W   = 48;
  localparam logic [6:0]  SD_CRC7_POLY = 7'h09;

  localparam logic [5:0] SD_CMD0  = 6'd0;
  localparam logic [5:0] SD_CMD8  = 6'd8;
  localparam logic [5:0] SD_CMD55 = 6'd55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_NCR_WAIT,
    ST_TX
  } resp_state_t;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_R1,
    RESP_R7
  } resp_type_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, zero seed), MSB-first bit input.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line responder: receives 48-bit commands, answers with R1/R7.
// Build option: define SD_RESP_CRC_CHECK_EN to reject commands with a bad CRC7.
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int unsigned NCR         = 2,
  parameter logic [31:0] CARD_STATUS = 32'h0000_0100,
  parameter logic [3:0]  VHS_ACCEPT  = 4'b0001
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SD_CLK,
  input  logic        CMD_IN,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  output logic        CMD_VALID,
  output logic [5:0]  CMD_IDX,
  output logic [31:0] CMD_ARG,
  output logic        CRC_ERR
);

  localparam logic [6:0] NCR_LAST = 7'(NCR - 1);

  logic [2:0]  sclk_sync;
  logic [2:0]  cmd_sync;
  logic        rise;
  logic        fall;
  logic        cmd_bit;

  resp_state_t state;
  logic [5:0]  bit_cnt;
  logic [45:0] sr;
  logic [6:0]  ncr_cnt;
  logic [5:0]  tx_cnt;
  logic [39:0] tx_hdr;

  logic        crc_clr;
  logic        crc_en;
  logic        crc_din;
  logic [6:0]  crc_out;
  logic        crc_bad;
  logic        tx_bit;
  resp_type_t  rtype;
  logic [39:0] hdr_next;

  assign cmd_bit = cmd_sync[2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= '0;
      cmd_sync  <= '1;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SD_CLK};
      cmd_sync  <= {cmd_sync[1:0], CMD_IN};
      rise      <= sclk_sync[1] & ~sclk_sync[2];
      fall      <= ~sclk_sync[1] & sclk_sync[2];
    end
  end

  sd_crc7 u_crc (
    .clk (CLK),
    .rst (RST),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_out)
  );

  // One generator: checks received bits in RX, builds the response CRC in TX.
  always_comb begin
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = cmd_bit;
    case (state)
      ST_IDLE, ST_CHECK: crc_clr = 1'b1;
      ST_RX:             crc_en  = rise && (bit_cnt < 6'd39);
      ST_NCR_WAIT: begin
        crc_en  = fall && (ncr_cnt == NCR_LAST);
        crc_din = tx_hdr[39];
      end
      ST_TX: begin
        crc_en  = fall && (tx_cnt < 6'd40);
        crc_din = tx_hdr[39];
      end
      default: ;
    endcase
  end

  always_comb begin
    if (tx_cnt < 6'd40) begin
      tx_bit = tx_hdr[39];
    end else if (tx_cnt < 6'd47) begin
      tx_bit = crc_out[3'(6'd46 - tx_cnt)];
    end else begin
      tx_bit = 1'b1;
    end
  end

`ifdef SD_RESP_CRC_CHECK_EN
  assign crc_bad = (crc_out != sr[7:1]);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    rtype    = RESP_R1;
    hdr_next = {2'b00, sr[45:40], CARD_STATUS};
    if (sr[45:40] == SD_CMD0) begin
      rtype = RESP_NONE;
    end else if (sr[45:40] == SD_CMD8) begin
      rtype    = RESP_R7;
      hdr_next = {2'b00, SD_CMD8, 20'd0, VHS_ACCEPT, sr[15:8]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      ncr_cnt   <= '0;
      tx_cnt    <= '0;
      tx_hdr    <= '0;
      CMD_OUT   <= 1'b1;
      CMD_OE    <= 1'b0;
      CMD_VALID <= 1'b0;
      CMD_IDX   <= '0;
      CMD_ARG   <= '0;
      CRC_ERR   <= 1'b0;
    end else begin
      CMD_VALID <= 1'b0;
      CRC_ERR   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise && !cmd_bit) begin
            bit_cnt <= '0;
            state   <= ST_RX;
          end
        end
        ST_RX: begin
          if (rise) begin
            sr      <= {sr[44:0], cmd_bit};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd0 && !cmd_bit) begin
              state <= ST_IDLE;
            end else if (bit_cnt == 6'd46) begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!sr[0]) begin
            state <= ST_IDLE;
          end else if (crc_bad) begin
            CRC_ERR <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            CMD_VALID <= 1'b1;
            CMD_IDX   <= sr[45:40];
            CMD_ARG   <= sr[39:8];
            tx_hdr    <= hdr_next;
            ncr_cnt   <= '0;
            state     <= (rtype == RESP_NONE) ? ST_IDLE : ST_NCR_WAIT;
          end
        end
        ST_NCR_WAIT: begin
          if (fall) begin
            if (ncr_cnt == NCR_LAST) begin
              CMD_OE  <= 1'b1;
              CMD_OUT <= tx_hdr[39];
              tx_hdr  <= {tx_hdr[38:0], 1'b0};
              tx_cnt  <= 6'd1;
              state   <= ST_TX;
            end else begin
              ncr_cnt <= ncr_cnt + 7'd1;
            end
          end
        end
        ST_TX: begin
          if (fall) begin
            if (tx_cnt == 6'd48) begin
              CMD_OE  <= 1'b0;
              CMD_OUT <= 1'b1;
              tx_cnt  <= '0;
              state   <= ST_IDLE;
            end else begin
              CMD_OUT <= tx_bit;
              tx_cnt  <= tx_cnt + 6'd1;
              if (tx_cnt < 6'd40) begin
                tx_hdr <= {tx_hdr[38:0], 1'b0};
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: directed frames plus random commands checked
// against a reference that builds frames and CRC7 by polynomial division.
module tb_sd_cmd_responder;

  localparam int unsigned NCR_TB = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SD_CLK = 1'b0;
  logic        CMD_IN = 1'b1;
  logic        CMD_OUT;
  logic        CMD_OE;
  logic        CMD_VALID;
  logic [5:0]  CMD_IDX;
  logic [31:0] CMD_ARG;
  logic        CRC_ERR;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_err = 0;

  sd_cmd_responder #(
    .NCR         (NCR_TB),
    .CARD_STATUS (32'h0000_0100),
    .VHS_ACCEPT  (4'b0001)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SD_CLK    (SD_CLK),
    .CMD_IN    (CMD_IN),
    .CMD_OUT   (CMD_OUT),
    .CMD_OE    (CMD_OE),
    .CMD_VALID (CMD_VALID),
    .CMD_IDX   (CMD_IDX),
    .CMD_ARG   (CMD_ARG),
    .CRC_ERR   (CRC_ERR)
  );

  always #5 CLK = ~CLK;
  always #60 SD_CLK = ~SD_CLK;

  always @(posedge CLK) begin
    if (CMD_VALID === 1'b1) n_valid++;
    if (CRC_ERR === 1'b1) n_err++;
  end

  // Remainder of m(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_div(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_div(body), 1'b1};
  endfunction

  function automatic logic [47:0] model_resp(input logic [47:0] cmd);
    logic [39:0] body;
    if (cmd[45:40] == 6'd8) body = {2'b00, 6'd8, 20'd0, 4'b0001, cmd[15:8]};
    else                    body = {2'b00, cmd[45:40], 32'h0000_0100};
    return {body, crc7_div(body), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge SD_CLK);
      #1 CMD_IN = f[i];
    end
    @(posedge SD_CLK);
  endtask

  task automatic run_cmd(input logic [47:0] f, input string tag, input bit exp_acc,
                         input bit exp_err, input bit exp_rsp, input logic [47:0] rsp);
    int v0, e0, first, cnt;
    logic [47:0] cap;
    v0 = n_valid; e0 = n_err; first = 0; cnt = 0; cap = '0;
    send_bits(f);
    #1 CMD_IN = 1'b1;
    for (int r = 1; r <= 100; r++) begin
      @(posedge SD_CLK);
      if (CMD_OE === 1'b1) begin
        if (first == 0) first = r;
        cap = {cap[46:0], CMD_OUT};
        cnt++;
      end
    end
    chk({tag, " valid_pulses"}, 48'(n_valid - v0), 48'(exp_acc));
    chk({tag, " crc_err_pulses"}, 48'(n_err - e0), 48'(exp_err));
    if (exp_acc) begin
      chk({tag, " idx"}, 48'(CMD_IDX), 48'(f[45:40]));
      chk({tag, " arg"}, 48'(CMD_ARG), 48'(f[39:8]));
    end
    chk({tag, " oe_periods"}, 48'(cnt), exp_rsp ? 48'd48 : 48'd0);
    if (exp_rsp) begin
      chk({tag, " start_rise"}, 48'(first), 48'(NCR_TB));
      chk({tag, " response"}, cap, rsp);
    end
  endtask

  initial begin
    logic [47:0] f;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    int          cnt, v0;

    repeat (5) @(posedge CLK);
    #1;
    chk("reset cmd_out", 48'(CMD_OUT), 48'd1);
    chk("reset cmd_oe", 48'(CMD_OE), 48'd0);
    chk("reset valid", 48'(CMD_VALID), 48'd0);
    chk("reset idx", 48'(CMD_IDX), 48'd0);
    chk("reset arg", 48'(CMD_ARG), 48'd0);
    chk("reset crc_err", 48'(CRC_ERR), 48'd0);
    RST = 1'b0;
    repeat (4) @(posedge SD_CLK);

    f = 48'h40_0000_0000_95;
    chk("cmd0 model crc", 48'(crc7_div(f[47:8])), 48'(f[7:1]));
    run_cmd(f, "cmd0", 1'b1, 1'b0, 1'b0, '0);

    f = 48'h48_0000_01AA_87;
    chk("cmd8 model resp", model_resp(f), 48'h08_0000_01AA_13);
    run_cmd(f, "cmd8", 1'b1, 1'b0, 1'b1, 48'h08_0000_01AA_13);

    f = 48'h48_0000_01AA_01;
`ifdef SD_RESP_CRC_CHECK_EN
    run_cmd(f, "cmd8 badcrc", 1'b0, 1'b1, 1'b0, '0);
`else
    run_cmd(f, "cmd8 badcrc", 1'b1, 1'b0, 1'b1, 48'h08_0000_01AA_13);
`endif

    f = 48'h77_0000_0000_65;
    run_cmd(f, "cmd55", 1'b1, 1'b0, 1'b1, model_resp(f));

    // Start bit then a 0 transmission bit: must abort silently.
    v0 = n_valid + n_err;
    @(negedge SD_CLK); #1 CMD_IN = 1'b0;
    @(negedge SD_CLK); #1 CMD_IN = 1'b0;
    @(negedge SD_CLK); #1 CMD_IN = 1'b1;
    repeat (60) @(posedge SD_CLK);
    chk("abort no pulses", 48'(n_valid + n_err - v0), 48'd0);
    chk("abort oe", 48'(CMD_OE), 48'd0);
    run_cmd(48'h40_0000_0000_95, "after abort cmd0", 1'b1, 1'b0, 1'b0, '0);

    // Reset in the middle of a response.
    f = 48'h48_0000_01AA_87;
    send_bits(f);
    #1 CMD_IN = 1'b1;
    cnt = 0;
    for (int r = 0; r < 80 && cnt < 20; r++) begin
      @(posedge SD_CLK);
      if (CMD_OE === 1'b1) cnt++;
    end
    chk("midtx reached bit20", 48'(cnt), 48'd20);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;
    chk("midtx rst oe", 48'(CMD_OE), 48'd0);
    chk("midtx rst out", 48'(CMD_OUT), 48'd1);
    chk("midtx rst valid", 48'(CMD_VALID), 48'd0);
    RST = 1'b0;
    cnt = 0;
    for (int r = 0; r < 60; r++) begin
      @(posedge SD_CLK);
      if (CMD_OE === 1'b1) cnt++;
    end
    chk("midtx stays released", 48'(cnt), 48'd0);
    run_cmd(f, "cmd8 after rst", 1'b1, 1'b0, 1'b1, 48'h08_0000_01AA_13);

    for (int k = 0; k < 6; k++) begin
      ridx = (k == 1) ? 6'd8 : 6'($urandom_range(0, 63));
      rarg = $urandom;
      f = make_cmd(ridx, rarg);
      run_cmd(f, $sformatf("rand%0d idx%0d", k, ridx), 1'b1, 1'b0,
              (ridx != 6'd0), model_resp(f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
